frame_deframer: RTL
===================

FRAME_DEFRAMER -- requirements
Module: frame_deframer

Interface
REQ-001 Parameter FRAME_LEN, default 102, total bits per frame.
REQ-002 Parameter HDR_LEN, default 6, header bits at frame start.
REQ-003 Parameter LOSS_THRESH, default 3, consecutive bad headers that drop lock.
REQ-004 Parameter FIFO_DEPTH, default 4, output word buffer depth.
REQ-005 Port clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port in_valid  input  1  demodulated bit valid (AXIS).
REQ-008 Port in_data  input  1  demodulated bit.
REQ-009 Port in_ready  output  1  bit accepted when in_valid && in_ready.
REQ-010 Port out_valid  output  1  payload word valid (AXIS, to FIFO).
REQ-011 Port out_data  output  32  payload word.
REQ-012 Port out_ready  input  1  downstream ready.
REQ-013 Port locked  output  1  high while in LOCKED state.
REQ-014 Port hdr_err  output  1  one-cycle pulse per invalid header.

Function
REQ-015 Frame format SHALL be: bits 0..5 header, bits 6..101 payload, first-received bit is bit 0.
REQ-016 Header 111111 = idle frame; payload = 0,0,1,1,0,0,... (pairs alternating, starting 00).
REQ-017 Header 000000 = data frame; payload = three 32-bit words, each MSB first, in order.
REQ-018 Any other header SHALL be an invalid header.
REQ-019 States: HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-020 HUNT: last 102 accepted bits SHALL be held in a shift register; exact match against the full idle frame -> VERIFY, bit_cnt := 0 (next accepted bit is header bit 0).
REQ-021 VERIFY/LOCKED: bit_cnt SHALL count accepted bits 0..101 and wrap to 0.
REQ-022 Header evaluated on acceptance of bit_cnt=5; VERIFY: valid -> LOCKED, invalid -> HUNT with hdr_err pulse.
REQ-023 LOCKED: invalid header -> hdr_err pulse, miss_cnt += 1; miss_cnt reaching LOSS_THRESH -> HUNT, miss_cnt := 0; valid header -> miss_cnt := 0.
REQ-024 hdr_err SHALL be asserted the cycle after the 6th header bit is accepted.
REQ-025 Payload of idle and invalid-header frames SHALL be discarded; idle payload content is not checked in LOCKED.
REQ-026 Data frame: payload bits shifted into a 32-bit word register; word pushed to FIFO on acceptance of bit_cnt 37, 69, 101.
REQ-027 Only data frames in VERIFY->LOCKED transition or LOCKED state produce words; HUNT never pushes.
REQ-028 in_ready SHALL equal !fifo_full, independent of state.
REQ-029 Push and pop in the same cycle SHALL both occur when FIFO not full; order preserved.
REQ-030 out_valid = !fifo_empty; out_data = FIFO head; pop on out_valid && out_ready.
REQ-031 Loss of lock mid data frame SHALL discard the partial word; words already in FIFO remain and drain.
REQ-032 Latency: word pushed on the accepting edge of its last bit; out_valid high the following cycle.

Reset
REQ-033 rst_n low SHALL immediately clear: state=HUNT, bit_cnt=0, miss_cnt=0, shift register=0, FIFO empty, out_valid=0, out_data=0, locked=0, hdr_err=0.
REQ-034 in_ready SHALL be 1 while rst_n high and FIFO empty after reset; reset mid-frame discards all partial data.
REQ-035 Reset release SHALL require a fresh HUNT match before any word is output.

Structure
REQ-036 Package framing_pkg SHALL hold FRAME_LEN, HDR_LEN, PAYLOAD_LEN (96), WORD_W (32), IDLE_FRAME 102-bit constant, HDR_IDLE/HDR_DATA constants, and the deframer state enum.
REQ-037 One sub-module sync_fifo (32-bit, FIFO_DEPTH entries, full/empty flags, async active-low reset) SHALL implement the output buffer.

Verification
REQ-038 Two idle frames after reset -> VERIFY after bit 101, locked=1 after bit 107, out_valid stays 0.
REQ-039 Idle frame, then data frame payload 0xDEADBEEF, 0x01234567, 0x89ABCDEF -> exactly those three words in order, no hdr_err.
REQ-040 Locked, out_ready=0, two data frames -> FIFO holds 4 words, in_ready drops, no bit lost; out_ready=1 -> 6 words in order.
REQ-041 Locked, three consecutive headers 101010 -> three hdr_err pulses, locked falls after third; two bad then 000000 -> locked stays 1.
REQ-042 300 all-zero bits after reset -> state HUNT, locked=0, out_valid=0 throughout.
REQ-043 rst_n pulsed low after 50 payload bits of a data frame -> all outputs cleared asynchronously, no partial word emitted, re-lock needs idle frame.

Source files
------------

// File: rtl/framing_pkg.sv
// framing_pkg: shared frame geometry, header codes, idle reference frame and deframer states.
package framing_pkg;
  localparam int FRAME_LEN   = 102;
  localparam int HDR_LEN     = 6;
  localparam int PAYLOAD_LEN = FRAME_LEN - HDR_LEN;
  localparam int WORD_W      = 32;
  localparam logic [HDR_LEN-1:0] HDR_IDLE = 6'b111111;
  localparam logic [HDR_LEN-1:0] HDR_DATA = 6'b000000;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;
  // First-received bit sits at the MSB; idle payload runs 0,0,1,1,0,0,...
  function automatic logic [FRAME_LEN-1:0] make_idle();
    logic [FRAME_LEN-1:0] f;
    for (int i = 0; i < FRAME_LEN; i++)
      f[FRAME_LEN-1-i] = (i < HDR_LEN) || ((i - HDR_LEN) % 4 >= 2);
    return f;
  endfunction
  localparam logic [FRAME_LEN-1:0] IDLE_FRAME = make_idle();
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word buffer with full/empty flags and async active-low reset.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wptr_d = do_push ? (wptr_q == AW'(DEPTH-1) ? '0 : wptr_q + AW'(1)) : wptr_q;
    rptr_d = do_pop ? (rptr_q == AW'(DEPTH-1) ? '0 : rptr_q + AW'(1)) : rptr_q;
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= wdata;
    end
  end
endmodule

// File: rtl/frame_deframer.sv
// frame_deframer: hunts for the idle frame, tracks header lock, and emits data-frame
// payload as 32-bit words through an output FIFO.
module frame_deframer #(
  parameter int FRAME_LEN   = 102,
  parameter int HDR_LEN     = 6,
  parameter int LOSS_THRESH = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        locked,
  output logic        hdr_err
);
  import framing_pkg::*;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [MW-1:0]         miss_q, miss_d;
  logic [FRAME_LEN-1:0]  sr_q, sr_d;
  logic                  is_data_q, is_data_d, locked_q, locked_d, hdr_err_q, hdr_err_d;
  logic                  accept, push, full, empty, word_end, hdr_ok;
  logic [HDR_LEN-1:0]    hdr;
  assign accept    = in_valid && in_ready;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign locked    = locked_q;
  assign hdr_err   = hdr_err_q;
  assign hdr       = sr_d[HDR_LEN-1:0];
  assign hdr_ok    = hdr == HDR_DATA || hdr == HDR_IDLE;
  assign word_end  = bit_cnt_q == CW'(HDR_LEN + WORD_W - 1) ||
                     bit_cnt_q == CW'(HDR_LEN + 2*WORD_W - 1) ||
                     bit_cnt_q == CW'(FRAME_LEN - 1);
  // The low word of the shift register is the payload word being assembled, MSB first.
  assign push      = accept && state_q == LOCKED && is_data_q && word_end;
  always_comb begin
    sr_d      = accept ? {sr_q[FRAME_LEN-2:0], in_data} : sr_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    miss_d    = miss_q;
    is_data_d = is_data_q;
    hdr_err_d = 1'b0;
    if (accept && state_q == HUNT) begin
      if (sr_d == IDLE_FRAME) begin
        state_d   = VERIFY;
        bit_cnt_d = '0;
      end
    end else if (accept) begin
      bit_cnt_d = bit_cnt_q == CW'(FRAME_LEN-1) ? '0 : bit_cnt_q + CW'(1);
      if (bit_cnt_q == CW'(HDR_LEN-1)) begin
        is_data_d = hdr == HDR_DATA;
        hdr_err_d = !hdr_ok;
        if (hdr_ok) begin
          state_d = LOCKED;
          miss_d  = '0;
        end else if (state_q == VERIFY || miss_q == MW'(LOSS_THRESH-1)) begin
          state_d   = HUNT;
          miss_d    = '0;
          bit_cnt_d = '0;
        end else begin
          miss_d = miss_q + MW'(1);
        end
      end
    end
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      miss_q    <= '0;
      sr_q      <= '0;
      is_data_q <= 1'b0;
      locked_q  <= 1'b0;
      hdr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      miss_q    <= miss_d;
      sr_q      <= sr_d;
      is_data_q <= is_data_d;
      locked_q  <= locked_d;
      hdr_err_q <= hdr_err_d;
    end
  end
  sync_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (sr_d[WORD_W-1:0]),
    .pop   (out_ready),
    .full  (full),
    .empty (empty),
    .rdata (out_data)
  );
endmodule
